// File: rtl/seq_mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states and default sizing.
package seq_mul_div_unit_pkg;

  localparam int DEFAULT_WIDTH      = 64;
  localparam int DEFAULT_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_UDIV = 2'b01,
    OP_SDIV = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_mdu_step.sv
// One radix-2 iteration on the {acc, a, b} datapath: shift-add for multiply,
// restoring shift-subtract for divide (quotient bits shift into a).
module seq_mdu_step #(
  parameter int WIDTH = 64
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  always_comb begin
    acc_next = acc;
    a_next   = a;
    b_next   = b;
    partial  = {acc, a[WIDTH-1]};
    diff     = partial - {1'b0, b};
    if (is_div) begin
      // acc stays below b, so a clear borrow bit means the subtraction fits
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        a_next   = {a[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = partial[WIDTH-1:0];
        a_next   = {a[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (b[0]) begin
        acc_next = acc + a;
      end
      a_next = a << 1;
      b_next = b >> 1;
    end
  end

endmodule

// File: rtl/seq_mul_div_unit.sv
// Iterative multiply/divide unit feeding the register bank write port;
// fixed latency of WIDTH+1 cycles from accept to the done pulse.
module seq_mul_div_unit
  import seq_mul_div_unit_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [REG_ADDR_W-1:0] result_reg,
  output logic                  write
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      count;
  op_t                   op_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [WIDTH-1:0]      acc_q;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic                  negate_q;
  logic                  div_zero_q;
  logic [WIDTH-1:0]      acc_step;
  logic [WIDTH-1:0]      a_step;
  logic [WIDTH-1:0]      b_step;
  logic [WIDTH-1:0]      abs_a;
  logic [WIDTH-1:0]      abs_b;
  logic [WIDTH-1:0]      fix_value;
  logic                  accept;
  logic                  is_div;

  assign accept = start && (state == IDLE || state == DONE);
  assign is_div = (op_q == OP_UDIV) || (op_q == OP_SDIV);
  assign abs_a  = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b  = operand_b[WIDTH-1] ? -operand_b : operand_b;

  seq_mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc_q),
    .a        (a_q),
    .b        (b_q),
    .acc_next (acc_step),
    .a_next   (a_step),
    .b_next   (b_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // MIN/-1 falls out naturally: |MIN| is 2^(W-1) unsigned, and negating it wraps back to MIN
  always_comb begin
    fix_value = '0;
    case (op_q)
      OP_MUL:  fix_value = acc_q;
      OP_UDIV: fix_value = div_zero_q ? '0 : a_q;
      OP_SDIV: fix_value = div_zero_q ? '0 : (negate_q ? -a_q : a_q);
      default: fix_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      op_q       <= OP_MUL;
      dest_q     <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      negate_q   <= 1'b0;
      div_zero_q <= 1'b0;
      result     <= '0;
      result_reg <= '0;
    end else if (accept) begin
      count      <= '0;
      op_q       <= op_t'(op);
      dest_q     <= dest_reg;
      acc_q      <= '0;
      a_q        <= (op_t'(op) == OP_SDIV) ? abs_a : operand_a;
      b_q        <= (op_t'(op) == OP_SDIV) ? abs_b : operand_b;
      negate_q   <= (op_t'(op) == OP_SDIV) && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      div_zero_q <= (operand_b == '0);
    end else if (state == RUN) begin
      acc_q <= acc_step;
      a_q   <= a_step;
      b_q   <= b_step;
      count <= count + CNT_W'(1);
    end else if (state == FIX) begin
      result     <= fix_value;
      result_reg <= dest_q;
    end
  end

  assign busy  = (state == RUN) || (state == FIX);
  assign done  = (state == DONE);
  assign write = done && (op_q != OP_RSVD);

endmodule

// File: tb/tb_seq_mul_div_unit.sv
// Directed bench for seq_mul_div_unit: a vector table of single operations
// plus hand-written sequences for busy-start, back-to-back and reset abort.
module tb_seq_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [63:0] operand_a;
  logic [63:0] operand_b;
  logic [4:0]  dest_reg;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  result_reg;
  logic        write;

  int compared;
  int mismatched;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  dest;
    logic [63:0] exp_result;
    logic        exp_write;
  } vec_t;

  vec_t vecs[13];

  seq_mul_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .dest_reg   (dest_reg),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .result_reg (result_reg),
    .write      (write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Called #1 after a rising edge; start is held for exactly one edge, then inputs are scrambled
  task automatic apply_stimulus(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                                input logic [4:0] d);
    op        = o;
    operand_a = a;
    operand_b = b;
    dest_reg  = d;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    op        = 2'b11;
    operand_a = '1;
    operand_b = '0;
    dest_reg  = 5'h1f;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!done && cycles < 200);
  endtask

  initial begin
    int cycles;
    int pulses;
    int first_done;
    logic [63:0] first_result;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    op         = 2'b00;
    operand_a  = '0;
    operand_b  = '0;
    dest_reg   = '0;

    vecs[0]  = '{2'b00, 64'd7, 64'd6, 5'd3, 64'd42, 1'b1};
    vecs[1]  = '{2'b00, 64'hFFFFFFFFFFFFFFFD, 64'd5, 5'd7, 64'hFFFFFFFFFFFFFFF1, 1'b1};
    vecs[2]  = '{2'b00, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd8, 64'hFFFFFFFFFFFFFFFE, 1'b1};
    vecs[3]  = '{2'b00, 64'h0000000100000000, 64'h0000000100000000, 5'd9, 64'd0, 1'b1};
    vecs[4]  = '{2'b01, 64'd100, 64'd7, 5'd10, 64'd14, 1'b1};
    vecs[5]  = '{2'b01, 64'hFFFFFFFFFFFFFFFF, 64'h10, 5'd11, 64'h0FFFFFFFFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b10, 64'hFFFFFFFFFFFFFF9C, 64'd7, 5'd12, 64'hFFFFFFFFFFFFFFF2, 1'b1};
    vecs[7]  = '{2'b10, 64'd100, 64'hFFFFFFFFFFFFFFF9, 5'd13, 64'hFFFFFFFFFFFFFFF2, 1'b1};
    vecs[8]  = '{2'b10, 64'hFFFFFFFFFFFFFF9C, 64'hFFFFFFFFFFFFFFF9, 5'd14, 64'd14, 1'b1};
    vecs[9]  = '{2'b10, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd15, 64'h8000000000000000, 1'b1};
    vecs[10] = '{2'b01, 64'd5, 64'd0, 5'd16, 64'd0, 1'b1};
    vecs[11] = '{2'b10, 64'hFFFFFFFFFFFFFFFB, 64'd0, 5'd17, 64'd0, 1'b1};
    vecs[12] = '{2'b11, 64'd9, 64'd3, 5'd18, 64'd0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("reset busy", {63'd0, busy}, 64'd0);
    check_output("reset done", {63'd0, done}, 64'd0);
    check_output("reset write", {63'd0, write}, 64'd0);
    check_output("reset result", result, 64'd0);
    check_output("reset result_reg", {59'd0, result_reg}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
      check_output($sformatf("vec%0d busy", i), {63'd0, busy}, 64'd1);
      wait_done(cycles);
      check_output($sformatf("vec%0d latency", i), 64'(cycles), 64'd65);
      check_output($sformatf("vec%0d done", i), {63'd0, done}, 64'd1);
      check_output($sformatf("vec%0d write", i), {63'd0, write}, {63'd0, vecs[i].exp_write});
      check_output($sformatf("vec%0d result", i), result, vecs[i].exp_result);
      check_output($sformatf("vec%0d result_reg", i), {59'd0, result_reg}, {59'd0, vecs[i].dest});
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d done low", i), {63'd0, done}, 64'd0);
    end

    // A start raised while busy must be ignored entirely
    apply_stimulus(2'b00, 64'd7, 64'd6, 5'd3);
    pulses     = 0;
    first_done = 0;
    first_result = '0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 10) begin
        op = 2'b01; operand_a = 64'd100; operand_b = 64'd7; dest_reg = 5'd4; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          first_done   = c;
          first_result = result;
        end
      end
    end
    start = 1'b0;
    check_output("busy start pulses", 64'(pulses), 64'd1);
    check_output("busy start latency", 64'(first_done), 64'd65);
    check_output("busy start result", first_result, 64'd42);

    // Back-to-back: next op launched from the DONE cycle
    apply_stimulus(2'b01, 64'd100, 64'd7, 5'd4);
    wait_done(cycles);
    check_output("b2b first latency", 64'(cycles), 64'd65);
    check_output("b2b first result", result, 64'd14);
    apply_stimulus(2'b00, 64'd9, 64'd9, 5'd5);
    check_output("b2b second busy", {63'd0, busy}, 64'd1);
    wait_done(cycles);
    check_output("b2b second latency", 64'(cycles), 64'd65);
    check_output("b2b second result", result, 64'd81);
    check_output("b2b second result_reg", {59'd0, result_reg}, 64'd5);
    check_output("b2b second write", {63'd0, write}, 64'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a divide aborts with no done pulse
    apply_stimulus(2'b01, 64'd1000, 64'd3, 5'd6);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("abort busy", {63'd0, busy}, 64'd0);
    check_output("abort done", {63'd0, done}, 64'd0);
    check_output("abort write", {63'd0, write}, 64'd0);
    check_output("abort result", result, 64'd0);
    check_output("abort result_reg", {59'd0, result_reg}, 64'd0);
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check_output("abort no done", 64'(pulses), 64'd0);

    // Reset and start together: reset wins and the start is dropped
    op = 2'b00; operand_a = 64'd2; operand_b = 64'd3; dest_reg = 5'd2;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    check_output("rst+start busy", {63'd0, busy}, 64'd0);
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check_output("rst+start no done", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
